// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared types and constants for the FIFO write/read arbitration blocks
package fifo_arb_pkg;
  typedef enum logic [1:0] {IDLE, ARB, HOLD} fifo_arb_state_e;
  localparam int CNT_WIDTH      = 16;
  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_DATA_WIDTH = 16;
endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin picker, first valid index after last_ptr with wrap
// Ports: valid (request vector), last_ptr (last served index) -> sel (chosen index), any_valid
module rr_picker #(
  parameter int N = 4,
  localparam int PW = $clog2(N)
) (
  input  logic [N-1:0]  valid,
  input  logic [PW-1:0] last_ptr,
  output logic [PW-1:0] sel,
  output logic          any_valid
);
  logic [PW-1:0] idx;
  // Scan from the farthest distance down so the nearest valid index is written last and wins.
  always_comb begin
    sel = last_ptr;
    idx = last_ptr;
    for (int k = N; k >= 1; k--) begin
      idx = PW'((int'(last_ptr) + k) % N);
      if (valid[idx]) sel = idx;
    end
  end
  assign any_valid = |valid;
endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing one synchronous-FIFO write port among NUM_REQ producers
// Ports: clk, rst_n (async, active low); req_valid/req_data/req_ready producer handshakes;
//   fifo_wr_en/fifo_data_in registered FIFO write; fifo_full/almostfull/wr_ack/overflow FIFO status;
//   grant_id last accepted producer; drop_err sticky unacknowledged-write flag, clr_err clears it;
//   grant_cnt per-producer accept counters, present only when FIFO_ARB_STATS_EN is defined (else 0).
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  localparam int PW = $clog2(NUM_REQ)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic                            fifo_wr_en,
  output logic [DATA_WIDTH-1:0]           fifo_data_in,
  input  logic                            fifo_full,
  input  logic                            fifo_almostfull,
  input  logic                            fifo_wr_ack,
  input  logic                            fifo_overflow,
  output logic [PW-1:0]                   grant_id,
  output logic                            drop_err,
  input  logic                            clr_err,
  output logic [NUM_REQ*CNT_WIDTH-1:0]    grant_cnt
);
  fifo_arb_state_e       state_q, state_d;
  logic [PW-1:0]         last_ptr_q, last_ptr_d;
  logic [PW-1:0]         lock_q, lock_d;
  logic                  wr_en_q, wr_en_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [PW-1:0]         grant_id_q, grant_id_d;
  logic                  wr_pend_q, wr_pend_d;
  logic                  drop_err_q, drop_err_d;
  logic [PW-1:0]         sel, tsel;
  logic                  any_valid, can_write, fire;

  rr_picker #(.N(NUM_REQ)) u_picker (
    .valid     (req_valid),
    .last_ptr  (last_ptr_q),
    .sel       (sel),
    .any_valid (any_valid)
  );

  // A write still in flight will fill the last slot, so almostfull alone blocks when wr_en is up.
  assign can_write = !fifo_full && !(fifo_almostfull && wr_en_q);
  assign tsel      = (state_q == HOLD) ? lock_q : sel;
  assign fire      = |(req_valid & req_ready);

  always_comb begin
    req_ready = '0;
    if (can_write) begin
      if (state_q == HOLD) req_ready[lock_q] = req_valid[lock_q];
      else if (any_valid) req_ready[sel] = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    lock_d  = lock_q;
    if (state_q != HOLD && any_valid && !can_write) begin
      state_d = HOLD;
      lock_d  = sel;
    end else if (state_q != HOLD || can_write) begin
      state_d = any_valid ? ARB : IDLE;
    end
    last_ptr_d = fire ? tsel : last_ptr_q;
    wr_en_d    = fire;
    data_d     = fire ? req_data[tsel*DATA_WIDTH +: DATA_WIDTH] : data_q;
    grant_id_d = fire ? tsel : grant_id_q;
    wr_pend_d  = wr_en_q;
    // A new drop in the same cycle as clr_err keeps the flag set.
    drop_err_d = (wr_pend_q && (!fifo_wr_ack || fifo_overflow)) || (drop_err_q && !clr_err);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      last_ptr_q <= PW'(NUM_REQ - 1);
      lock_q     <= '0;
      wr_en_q    <= 1'b0;
      data_q     <= '0;
      grant_id_q <= '0;
      wr_pend_q  <= 1'b0;
      drop_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_ptr_q <= last_ptr_d;
      lock_q     <= lock_d;
      wr_en_q    <= wr_en_d;
      data_q     <= data_d;
      grant_id_q <= grant_id_d;
      wr_pend_q  <= wr_pend_d;
      drop_err_q <= drop_err_d;
    end
  end

  assign fifo_wr_en   = wr_en_q;
  assign fifo_data_in = data_q;
  assign grant_id     = grant_id_q;
  assign drop_err     = drop_err_q;

`ifdef FIFO_ARB_STATS_EN
  logic [NUM_REQ-1:0][CNT_WIDTH-1:0] cnt_q, cnt_d;
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++)
      cnt_d[i] = (fire && int'(tsel) == i && cnt_q[i] != '1) ? cnt_q[i] + CNT_WIDTH'(1) : cnt_q[i];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign grant_cnt = cnt_q;
`else
  assign grant_cnt = '0;
`endif
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed self-checking bench for fifo_wr_arbiter against a depth-8 FIFO model
module tb_fifo_wr_arbiter;
  localparam int N  = 4;
  localparam int DW = 16;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0] req_valid = '0;
  logic [N-1:0] req_ready;
  logic [N*DW-1:0] req_data = {16'hA300, 16'hA200, 16'hA100, 16'hA000};
  logic fifo_wr_en;
  logic [DW-1:0] fifo_data_in;
  logic fifo_full, fifo_almostfull, fifo_wr_ack, fifo_overflow;
  logic [1:0] grant_id;
  logic drop_err;
  logic clr_err = 1'b0;
  logic [N*16-1:0] grant_cnt;
  int cnt;
  int fill_set = -1;
  logic rd_en = 1'b0;
  logic ack_kill = 1'b0;
  logic ack_r, ovf_r;
  logic [DW-1:0] log_q[$];
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .fifo_wr_en(fifo_wr_en), .fifo_data_in(fifo_data_in),
    .fifo_full(fifo_full), .fifo_almostfull(fifo_almostfull),
    .fifo_wr_ack(fifo_wr_ack), .fifo_overflow(fifo_overflow),
    .grant_id(grant_id), .drop_err(drop_err), .clr_err(clr_err), .grant_cnt(grant_cnt)
  );

  // Depth-8 FIFO environment: flags from occupancy, registered ack/overflow, optional preload.
  assign fifo_full       = (cnt == 8);
  assign fifo_almostfull = (cnt == 7);
  assign fifo_wr_ack     = ack_r && !ack_kill;
  assign fifo_overflow   = ovf_r;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= 0;
      ack_r <= 1'b0;
      ovf_r <= 1'b0;
    end else begin
      ack_r <= fifo_wr_en && cnt < 8;
      ovf_r <= fifo_wr_en && cnt == 8;
      if (fill_set >= 0) cnt <= fill_set;
      else cnt <= cnt + int'(fifo_wr_en && cnt < 8) - int'(rd_en && cnt > 0);
      if (fifo_wr_en && cnt < 8) log_q.push_back(fifo_data_in);
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0;
    rd_en = 1'b0;
    ack_kill = 1'b0;
    clr_err = 1'b0;
    fill_set = -1;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_wr_en", 64'(fifo_wr_en), 64'h0);
    chk("rst_data", 64'(fifo_data_in), 64'h0);
    chk("rst_grant_id", 64'(grant_id), 64'h0);
    chk("rst_drop_err", 64'(drop_err), 64'h0);
    chk("rst_grant_cnt", grant_cnt, 64'h0);
    chk("rst_ready", 64'(req_ready), 64'h0);
    rst_n = 1'b1;
    tick();

    // Sustained all-valid rotation into an empty FIFO, then blocked at almostfull/full.
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk($sformatf("rr_ready_%0d", k), 64'(req_ready), 64'(4'b0001 << (k % 4)));
      tick();
      chk($sformatf("rr_wr_en_%0d", k), 64'(fifo_wr_en), 64'h1);
      chk($sformatf("rr_data_%0d", k), 64'(fifo_data_in), 64'(16'hA000 + 16'(k % 4) * 16'h0100));
      chk($sformatf("rr_gid_%0d", k), 64'(grant_id), 64'(k % 4));
    end
    chk("af_inflight_ready", 64'(req_ready), 64'h0);
    tick();
    chk("full_wr_en", 64'(fifo_wr_en), 64'h0);
    chk("full_flag", 64'(fifo_full), 64'h1);
    chk("full_ready", 64'(req_ready), 64'h0);
    tick();
    chk("full_ready2", 64'(req_ready), 64'h0);
    chk("rr_log_size", 64'(log_q.size()), 64'd8);
    for (int j = 0; j < 8 && j < log_q.size(); j++)
      chk($sformatf("rr_log_%0d", j), 64'(log_q[j]), 64'(16'hA000 + 16'(j % 4) * 16'h0100));
    chk("rr_overflow", 64'(fifo_overflow), 64'h0);
    chk("rr_drop_err", 64'(drop_err), 64'h0);

    // FIFO at 7 words: exactly one write, then zero ready while it is in flight.
    do_reset();
    fill_set = 7;
    tick();
    fill_set = -1;
    req_valid = 4'b0100;
    #1;
    chk("af_ready", 64'(req_ready), 64'(4'b0100));
    tick();
    chk("af_wr_en", 64'(fifo_wr_en), 64'h1);
    chk("af_data", 64'(fifo_data_in), 64'hA200);
    chk("af_gid", 64'(grant_id), 64'h2);
    chk("af_ready_blocked", 64'(req_ready), 64'h0);
    tick();
    chk("af_full_ready", 64'(req_ready), 64'h0);
    chk("af_full_wr_en", 64'(fifo_wr_en), 64'h0);
    req_valid = '0;
    tick();
    tick();
    chk("af_overflow", 64'(fifo_overflow), 64'h0);
    chk("af_drop_err", 64'(drop_err), 64'h0);

    // HOLD locked to producer 3 wins over producer 1 once a slot frees.
    do_reset();
    req_valid = 4'b0001;
    #1;
    chk("hold_pre_ready", 64'(req_ready), 64'(4'b0001));
    tick();
    req_valid = '0;
    fill_set = 8;
    tick();
    fill_set = -1;
    req_valid = 4'b1000;
    #1;
    chk("hold_full_ready", 64'(req_ready), 64'h0);
    tick();
    req_valid = 4'b1010;
    #1;
    chk("hold_ready_locked", 64'(req_ready), 64'h0);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    #1;
    chk("hold_release_ready", 64'(req_ready), 64'(4'b1000));
    tick();
    req_valid = '0;
    chk("hold_gid", 64'(grant_id), 64'h3);
    chk("hold_data", 64'(fifo_data_in), 64'hA300);
    chk("hold_wr_en", 64'(fifo_wr_en), 64'h1);
    tick();
    tick();
    chk("hold_drop_err", 64'(drop_err), 64'h0);

    // Missing wr_ack sets the sticky drop_err; clr_err clears it.
    do_reset();
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    tick();
    chk("ack_before", 64'(drop_err), 64'h0);
    ack_kill = 1'b1;
    tick();
    ack_kill = 1'b0;
    chk("ack_drop_set", 64'(drop_err), 64'h1);
    tick();
    chk("ack_drop_sticky", 64'(drop_err), 64'h1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("ack_drop_clr", 64'(drop_err), 64'h0);

    // Single requester re-granted every cycle; accept counters.
    do_reset();
    req_valid = 4'b0010;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("single_wr_en_%0d", k), 64'(fifo_wr_en), 64'h1);
    end
    req_valid = '0;
    tick();
    chk("single_gid", 64'(grant_id), 64'h1);
`ifdef FIFO_ARB_STATS_EN
    chk("stats_cnt", grant_cnt, 64'h0000_0000_0005_0000);
`else
    chk("stats_cnt", grant_cnt, 64'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
